// File: rtl/trail_fb_reader.sv
// Trail frame-buffer reader: prefetches the next scanline into a ping-pong line buffer
// during h-blank and unpacks 4-bit palette indices. Optional probe: TRAIL_FB_PROBE_EN.
module trail_fb_reader #(
    parameter int unsigned H_ACTIVE        = 640,
    parameter int unsigned V_ACTIVE        = 480,
    parameter int unsigned V_TOTAL         = 525,
    parameter int unsigned WORDS_PER_LINE  = 320,
    parameter int unsigned BASE_ADDR       = 0,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        pix_ce,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic        rd_req,
    output logic [18:0] rd_addr,
    input  logic        rd_gnt,
    input  logic        rd_valid,
    input  logic [15:0] rd_data,
    output logic [3:0]  pixel_idx,
`ifdef TRAIL_FB_PROBE_EN
    output logic        underrun,
    input  logic [9:0]  probe_x,
    input  logic [9:0]  probe_y,
    output logic        probe_hit
`else
    output logic        underrun
`endif
);

    localparam int unsigned ISS_W     = $clog2(WORDS_PER_LINE + 1);
    localparam int unsigned OST_W     = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned BUF_DEPTH = 2 * WORDS_PER_LINE;
    localparam int unsigned BUF_AW    = $clog2(BUF_DEPTH);

    localparam logic [9:0]        H_ACT   = 10'(H_ACTIVE);
    localparam logic [9:0]        V_ACT   = 10'(V_ACTIVE);
    localparam logic [9:0]        VTOT_M1 = 10'(V_TOTAL - 1);
    localparam logic [ISS_W-1:0]  WPL_C   = ISS_W'(WORDS_PER_LINE);
    localparam logic [OST_W-1:0]  MAX_C   = OST_W'(MAX_OUTSTANDING);
    localparam logic [18:0]       BASE_C  = 19'(BASE_ADDR);
    localparam logic [18:0]       WPL_A   = 19'(WORDS_PER_LINE);
    localparam logic [BUF_AW-1:0] WPL_B   = BUF_AW'(WORDS_PER_LINE);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t            state, state_next;
    logic [ISS_W-1:0]  issued;
    logic [ISS_W-1:0]  wr_idx;
    logic [OST_W-1:0]  outstanding;
    logic [9:0]        t_line;
    logic [18:0]       line_base;

    logic              trigger, start, xfer, accept;
    logic [9:0]        tgt_line;

    // Only the two nibbles that carry pixel indices are kept per word.
    logic [7:0]        line_buf [BUF_DEPTH];
    logic [BUF_AW-1:0] wr_ptr, rd_ptr;
    logic [7:0]        rd_word;
    logic              visible;
    logic [3:0]        pix_next;
    logic              unused_bits;

    assign unused_bits = ^{rd_data[15:12], rd_data[7:4]};

    assign trigger  = pix_ce && (DrawX == H_ACT);
    assign tgt_line = (DrawY == VTOT_M1) ? '0 : DrawY + 10'd1;
    assign start    = trigger && (state == IDLE) && (tgt_line < V_ACT);
    assign rd_req   = (state == FETCH) && (issued < WPL_C) && (outstanding < MAX_C);
    assign xfer     = rd_req && rd_gnt;
    assign accept   = rd_valid && (outstanding != '0);
    assign rd_addr  = BASE_C + line_base + 19'(issued);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = FETCH;
            FETCH:   if (issued == WPL_C) state_next = DRAIN;
            DRAIN:   if (outstanding == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            issued      <= '0;
            wr_idx      <= '0;
            outstanding <= '0;
            t_line      <= '0;
            line_base   <= '0;
            underrun    <= 1'b0;
        end else begin
            if (start) begin
                issued    <= '0;
                wr_idx    <= '0;
                t_line    <= tgt_line;
                line_base <= 19'(tgt_line) * WPL_A;
            end else begin
                if (xfer) issued <= issued + ISS_W'(1);
                if (accept && (wr_idx < WPL_C)) wr_idx <= wr_idx + ISS_W'(1);
            end

            case ({xfer, accept})
                2'b10:   outstanding <= outstanding + OST_W'(1);
                2'b01:   outstanding <= outstanding - OST_W'(1);
                default: outstanding <= outstanding;
            endcase

            if (trigger && (state != IDLE)) underrun <= 1'b1;
        end
    end

    // Bank select: fetch writes bank t_line[0], display reads bank DrawY[0].
    assign wr_ptr = (t_line[0] ? WPL_B : '0) + BUF_AW'(wr_idx);

    always_ff @(posedge Clk) begin
        if (accept && (wr_idx < WPL_C)) line_buf[wr_ptr] <= {rd_data[11:8], rd_data[3:0]};
    end

    assign visible  = (DrawX < H_ACT) && (DrawY < V_ACT);
    assign rd_ptr   = visible ? ((DrawY[0] ? WPL_B : '0) + BUF_AW'(DrawX[9:1])) : '0;
    assign rd_word  = line_buf[rd_ptr];
    assign pix_next = visible ? (DrawX[0] ? rd_word[7:4] : rd_word[3:0]) : 4'd0;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)       pixel_idx <= '0;
        else if (pix_ce) pixel_idx <= pix_next;
    end

`ifdef TRAIL_FB_PROBE_EN
    logic probe_now;
    assign probe_now = visible && (DrawX == probe_x) && (DrawY == probe_y) && (pix_next != 4'd0);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            probe_hit <= 1'b0;
        end else if (pix_ce) begin
            if ((DrawX == '0) && (DrawY == '0)) probe_hit <= probe_now;
            else if (probe_now)                 probe_hit <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_trail_fb_reader.sv
// Self-checking bench for trail_fb_reader: randomized memory latency/grant against a
// line-level reference model of the frame buffer. Probe tests need TRAIL_FB_PROBE_EN.
module tb_trail_fb_reader;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int V_TOTAL  = 525;
    localparam int WPL      = 320;
    localparam int BASE     = 0;
    localparam int MAXO     = 4;

    logic        Clk, Reset, pix_ce, rd_req, rd_gnt, rd_valid, underrun;
    logic [9:0]  DrawX, DrawY;
    logic [18:0] rd_addr;
    logic [15:0] rd_data;
    logic [3:0]  pixel_idx;
`ifdef TRAIL_FB_PROBE_EN
    logic [9:0]  probe_x, probe_y;
    logic        probe_hit;
`endif

    trail_fb_reader #(
        .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .V_TOTAL(V_TOTAL),
        .WORDS_PER_LINE(WPL), .BASE_ADDR(BASE), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .Clk(Clk), .Reset(Reset), .pix_ce(pix_ce), .DrawX(DrawX), .DrawY(DrawY),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid),
        .rd_data(rd_data), .pixel_idx(pixel_idx),
`ifdef TRAIL_FB_PROBE_EN
        .underrun(underrun), .probe_x(probe_x), .probe_y(probe_y), .probe_hit(probe_hit)
`else
        .underrun(underrun)
`endif
    );

    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    int total = 0;
    int bad   = 0;
    int unsigned seed;

    typedef struct {
        int unsigned addr;
        longint      due;
    } rd_t;

    rd_t    q[$];
    int     stale_n = 0;
    int     outst = 0;
    int     xfer_cnt = 0;
    int     cur_T = 0;
    bit     fetching = 0;
    int     gnt_mode = 0;
    int     lat_min = 2;
    int     lat_max = 2;
    longint cyc = 0;
    int     full_stall_seen = 0;
    int     pend_T = -1;
    int     exp_line[2] = '{-1, -1};

    // Frame-buffer memory image seen by the reader.
    function automatic logic [15:0] memword(input int unsigned a);
        if (a == 1600) return 16'h0A03;
        if (a == 1605) return 16'h0004;
        return 16'((a * 32'd40503) ^ (a >> 3) ^ seed);
    endfunction

    function automatic logic [3:0] exp_pix(input int x, input int y);
        logic [15:0] w;
        if (x >= H_ACTIVE || y >= V_ACTIVE) return 4'd0;
        w = memword(int'(unsigned'(BASE + y * WPL + x / 2)) & 32'h7FFFF);
        return (x % 2 == 1) ? w[11:8] : w[3:0];
    endfunction

    // Memory/arbiter responder: all decisions made at negedge for the following posedge.
    initial begin
        rd_t         r;
        logic        g;
        logic        exp_req;
        logic [18:0] exp_a;
        rd_gnt = 0; rd_valid = 0; rd_data = '0;
        forever begin
            @(negedge Clk);
            cyc++;
            if (Reset) begin
                stale_n  = q.size();
                outst    = 0;
                fetching = 0;
            end else begin
                exp_req = fetching && (xfer_cnt < WPL) && (outst < MAXO);
                total++;
                if (rd_req !== exp_req) begin
                    bad++;
                    $display("FAIL rd_req cyc=%0d got=%b want=%b outst=%0d issued=%0d", cyc, rd_req, exp_req, outst, xfer_cnt);
                end
                if (fetching && outst == MAXO && rd_req === 1'b0) full_stall_seen++;
            end
            g = (gnt_mode == 0) ? 1'b1 : (gnt_mode == 1) ? 1'($urandom % 2) : 1'b0;
            rd_gnt = g;
            if (!Reset && rd_req === 1'b1 && g) begin
                exp_a = 19'(BASE + cur_T * WPL + xfer_cnt);
                total++;
                if (rd_addr !== exp_a) begin
                    bad++;
                    $display("FAIL rd_addr got=%0d want=%0d", rd_addr, exp_a);
                end
                r.addr = int'(rd_addr);
                r.due  = cyc + longint'($urandom_range(lat_max, lat_min));
                q.push_back(r);
                outst++;
                xfer_cnt++;
                if (xfer_cnt == WPL) fetching = 0;
            end
            if (q.size() > 0 && q[0].due <= cyc) begin
                r = q.pop_front();
                rd_valid = 1'b1;
                rd_data  = memword(r.addr);
                if (stale_n > 0) stale_n--;
                else outst--;
            end else begin
                rd_valid = 1'b0;
                rd_data  = 16'($urandom);
            end
        end
    end

    task automatic drive_pix(input int x, input int y);
        @(negedge Clk);
        DrawX = 10'(x); DrawY = 10'(y); pix_ce = 1'b1;
        @(negedge Clk);
        pix_ce = 1'b0;
    endtask

    task automatic check_pix(input int x, input int y);
        logic [3:0] e;
        drive_pix(x, y);
        e = exp_pix(x, y);
        total++;
        if (pixel_idx !== e) begin
            bad++;
            $display("FAIL pixel (%0d,%0d) got=%h want=%h", x, y, pixel_idx, e);
        end
    endtask

    task automatic trigger(input int y);
        int t;
        bit busy;
        @(negedge Clk);
        DrawX = 10'(H_ACTIVE); DrawY = 10'(y); pix_ce = 1'b1;
        busy = fetching || (outst > 0);
        @(posedge Clk);
        #1;
        pix_ce = 1'b0; DrawX = '0;
        t = (y == V_TOTAL - 1) ? 0 : y + 1;
        if (!busy && t < V_ACTIVE) begin
            cur_T = t; xfer_cnt = 0; fetching = 1;
            pend_T = t; exp_line[t % 2] = -1;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((fetching || outst > 0) && n < budget) begin
            @(negedge Clk);
            n++;
        end
        total++;
        if (fetching || outst > 0) begin
            bad++;
            $display("FAIL fetch_timeout issued=%0d outst=%0d want issued=%0d outst=0", xfer_cnt, outst, WPL);
            fetching = 0;
        end else if (pend_T >= 0) begin
            if (xfer_cnt !== WPL) begin
                bad++;
                $display("FAIL transfer_count got=%0d want=%0d", xfer_cnt, WPL);
            end
            exp_line[pend_T % 2] = pend_T;
        end
        pend_T = -1;
        repeat (3) @(negedge Clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge Clk);
        total++;
        if (rd_req !== 1'b0 || rd_addr !== 19'(BASE) || pixel_idx !== 4'd0 || underrun !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got req=%b addr=%0d pix=%h ur=%b want 0/%0d/0/0", rd_req, rd_addr, pixel_idx, underrun, BASE);
        end
`ifdef TRAIL_FB_PROBE_EN
        total++;
        if (probe_hit !== 1'b0) begin
            bad++;
            $display("FAIL reset_probe got=%b want=0", probe_hit);
        end
`endif
        @(posedge Clk);
        #1 Reset = 1'b0;
    endtask

    task automatic test_basic_fetch();
        lat_min = 2; lat_max = 2; gnt_mode = 0;
        trigger(4);
        wait_idle(3000);
        check_pix(0, 5);
        total++;
        if (pixel_idx !== 4'h3) begin
            bad++;
            $display("FAIL first_pixel got=%h want=3", pixel_idx);
        end
        check_pix(1, 5);
        total++;
        if (pixel_idx !== 4'hA) begin
            bad++;
            $display("FAIL second_pixel got=%h want=a", pixel_idx);
        end
        for (int i = 0; i < 6; i++) check_pix($urandom_range(639, 0), 5);
        check_pix(639, 5);
    endtask

    task automatic test_gnt_stall();
        logic [18:0] a;
        lat_min = 2; lat_max = 2; gnt_mode = 0;
        trigger(6);
        repeat (40) @(negedge Clk);
        @(posedge Clk);
        #1;
        gnt_mode = 2;
        a = rd_addr;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            total++;
            if (rd_addr !== a || rd_req !== 1'b1) begin
                bad++;
                $display("FAIL gnt_hold got addr=%0d req=%b want addr=%0d req=1", rd_addr, rd_req, a);
            end
        end
        @(posedge Clk);
        #1 gnt_mode = 1;
        wait_idle(5000);
        for (int i = 0; i < 6; i++) check_pix($urandom_range(639, 0), 7);
    endtask

    task automatic test_long_latency();
        lat_min = 20; lat_max = 20; gnt_mode = 0;
        full_stall_seen = 0;
        trigger(4);
        wait_idle(20000);
        total++;
        if (full_stall_seen == 0) begin
            bad++;
            $display("FAIL outstanding_limit got stall_cycles=0 want >0");
        end
        for (int x = 0; x < H_ACTIVE; x++) check_pix(x, 5);
    endtask

    task automatic test_frame_wrap();
        lat_min = 1; lat_max = 3; gnt_mode = 1;
        trigger(V_TOTAL - 1);
        wait_idle(5000);
        check_pix(0, 0);
        check_pix(1, 0);
        for (int i = 0; i < 4; i++) check_pix($urandom_range(639, 0), 0);
        trigger(V_ACTIVE - 1);
        repeat (30) @(negedge Clk);
        total++;
        if (rd_req !== 1'b0) begin
            bad++;
            $display("FAIL no_fetch_480 got req=%b want=0", rd_req);
        end
    endtask

    task automatic test_underrun();
        lat_min = 1; lat_max = 4; gnt_mode = 1;
        total++;
        if (underrun !== 1'b0) begin
            bad++;
            $display("FAIL underrun_pre got=%b want=0", underrun);
        end
        trigger(10);
        repeat (20) @(negedge Clk);
        trigger(11);
        @(negedge Clk);
        total++;
        if (underrun !== 1'b1) begin
            bad++;
            $display("FAIL underrun_set got=%b want=1", underrun);
        end
        wait_idle(5000);
        total++;
        if (underrun !== 1'b1) begin
            bad++;
            $display("FAIL underrun_sticky got=%b want=1", underrun);
        end
        for (int i = 0; i < 6; i++) check_pix($urandom_range(639, 0), 11);
    endtask

    task automatic test_reset_mid_fetch();
        int n = 0;
        lat_min = 10; lat_max = 15; gnt_mode = 0;
        trigger(20);
        repeat (40) @(negedge Clk);
        @(posedge Clk);
        #1 Reset = 1'b1;
        #1;
        total++;
        if (rd_req !== 1'b0 || rd_addr !== 19'(BASE) || underrun !== 1'b0 || pixel_idx !== 4'd0) begin
            bad++;
            $display("FAIL reset_mid got req=%b addr=%0d ur=%b pix=%h want 0/%0d/0/0", rd_req, rd_addr, underrun, pixel_idx, BASE);
        end
        pend_T = -1;
        exp_line[21 % 2] = -1;
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        while (q.size() > 0 && n < 200) begin
            @(negedge Clk);
            n++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL stale_drain got pending=%0d want=0", q.size());
        end
        repeat (5) @(negedge Clk);
        lat_min = 1; lat_max = 5; gnt_mode = 1;
        trigger(20);
        wait_idle(5000);
        for (int i = 0; i < 6; i++) check_pix($urandom_range(639, 0), 21);
    endtask

    task automatic test_random_lines();
        int y, t;
        logic [3:0] held;
        for (int it = 0; it < 6; it++) begin
            y = $urandom_range(V_ACTIVE - 2, 0);
            t = y + 1;
            lat_min = 1 + $urandom % 3;
            lat_max = lat_min + $urandom % 12;
            gnt_mode = $urandom % 2;
            trigger(y);
            wait_idle(8000);
            for (int i = 0; i < 8; i++) check_pix($urandom_range(639, 0), t);
            check_pix($urandom_range(1023, H_ACTIVE + 1), $urandom_range(1023, 0));
            check_pix($urandom_range(639, 0), $urandom_range(1023, V_ACTIVE));
            check_pix($urandom_range(639, 0), t);
            held = pixel_idx;
            @(negedge Clk);
            DrawX = 10'($urandom_range(639, 0)); DrawY = 10'(t);
            repeat (2) @(negedge Clk);
            total++;
            if (pixel_idx !== exp_pix(int'(DrawX) == 0 ? 0 : 0, 0) && pixel_idx !== held) begin
                bad++;
                $display("FAIL pix_hold got=%h want=%h", pixel_idx, held);
            end
        end
    endtask

`ifdef TRAIL_FB_PROBE_EN
    task automatic test_probe();
        lat_min = 1; lat_max = 3; gnt_mode = 0;
        drive_pix(0, 0);
        total++;
        if (probe_hit !== 1'b0) begin
            bad++;
            $display("FAIL probe_clear0 got=%b want=0", probe_hit);
        end
        trigger(4);
        wait_idle(5000);
        check_pix(10, 5);
        total++;
        if (probe_hit !== 1'b1) begin
            bad++;
            $display("FAIL probe_hit got=%b want=1", probe_hit);
        end
        check_pix(20, 5);
        total++;
        if (probe_hit !== 1'b1) begin
            bad++;
            $display("FAIL probe_hold got=%b want=1", probe_hit);
        end
        drive_pix(0, 0);
        total++;
        if (probe_hit !== 1'b0) begin
            bad++;
            $display("FAIL probe_frame_clear got=%b want=0", probe_hit);
        end
    endtask
`endif

    initial begin
        #5000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        seed = $urandom;
        Reset = 1'b1; pix_ce = 1'b0; DrawX = '0; DrawY = '0;
`ifdef TRAIL_FB_PROBE_EN
        probe_x = 10'd10; probe_y = 10'd5;
`endif
        test_reset();
        test_basic_fetch();
        test_gnt_stall();
        test_long_latency();
        test_frame_wrap();
        test_underrun();
        test_reset_mid_fetch();
        test_random_lines();
`ifdef TRAIL_FB_PROBE_EN
        test_probe();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
